// File: rtl/weight_ram_ctrl.sv
// Weight RAM sequencer/arbiter: LFSR init sweep after reset or on request, then shares one RAM port.
// Define WCTRL_ROUND_ROBIN_EN for round-robin arbitration instead of fixed write priority.
module weight_ram_ctrl #(
  parameter int unsigned    DW    = 10,
  parameter int unsigned    AW    = 7,
  parameter int unsigned    DEPTH = 128,
  parameter logic [DW-1:0]  SEED  = 10'h1A5
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          init_req,
  output logic          init_busy,
  output logic          init_done,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [DW-1:0] lfsr_q;
  logic [AW-1:0] addr_q;
  logic          rd_valid_q;
  logic          init_done_q;
  logic          run_ok;
  logic          wr_pick;

  // No grants during the sweep nor in the cycle a new sweep is requested.
  assign run_ok = (state_q == StRun) && !init_req;

`ifdef WCTRL_ROUND_ROBIN_EN
  logic rr_last_q;  // 1: last grant went to the writer

  assign wr_pick = wr_req && (!rd_req || !rr_last_q);

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      rr_last_q <= 1'b0;
    end else if (wr_gnt) begin
      rr_last_q <= 1'b1;
    end else if (rd_gnt) begin
      rr_last_q <= 1'b0;
    end
  end
`else
  assign wr_pick = wr_req;
`endif

  assign wr_gnt = run_ok && wr_pick;
  assign rd_gnt = run_ok && rd_req && !wr_pick;

  // The address is held at its last value whenever the port is idle.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_d    = '0;
    if (state_q == StInit) begin
      ram_we   = 1'b1;
      ram_addr = cnt_q;
      ram_d    = lfsr_q;
    end else if (wr_gnt) begin
      ram_we   = 1'b1;
      ram_addr = wr_addr;
      ram_d    = wr_data;
    end else if (rd_gnt) begin
      ram_addr = rd_addr;
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      lfsr_q      <= SEED;
      addr_q      <= '0;
      rd_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      addr_q      <= ram_addr;
      rd_valid_q  <= rd_gnt;
      init_done_q <= 1'b0;
      unique case (state_q)
        StInit: begin
          lfsr_q <= {lfsr_q[DW-2:0], lfsr_q[DW-1] ^ lfsr_q[DW-4]};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LastAddr) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
        end
        StRun: begin
          // LFSR keeps running state, so a re-sweep produces fresh weights.
          if (init_req) begin
            state_q <= StInit;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign init_busy = (state_q == StInit);
  assign init_done = init_done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = ram_q;

endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Randomized bench for weight_ram_ctrl against a cycle-level reference model with a RAM model.
module tb_weight_ram_ctrl;
  localparam int DW = 10;
  localparam int AW = 7;
  localparam int DEPTH = 128;
  localparam logic [DW-1:0] SEED = 10'h1A5;

  logic          Clock = 1'b0;
  logic          Rst;
  logic          init_req = 1'b0;
  logic          init_busy, init_done;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt, rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d;
  logic          ram_we;
  logic [DW-1:0] ram_q = '0;

  weight_ram_ctrl dut (
    .Clock    (Clock),
    .Rst      (Rst),
    .init_req (init_req),
    .init_busy(init_busy),
    .init_done(init_done),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_gnt   (wr_gnt),
    .ram_addr (ram_addr),
    .ram_d    (ram_d),
    .ram_we   (ram_we),
    .ram_q    (ram_q)
  );

  always #5 Clock = ~Clock;

  // Single-port RAM with registered read data.
  logic [DW-1:0] mem [2**AW];
  always @(posedge Clock) begin
    if (ram_we) mem[ram_addr] <= ram_d;
    else ram_q <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] x);
    int v, fb;
    v  = int'(x);
    fb = ((v / 512) + ((v / 64) % 2)) % 2;
    return DW'((2 * v + fb) % 1024);
  endfunction

  // Reference model state
  bit            m_busy, m_done, m_rv, m_rr_wr_last;
  int            m_idx;
  logic [DW-1:0] m_lfsr, m_rdata;
  logic [DW-1:0] m_mem [DEPTH];
  logic [AW-1:0] m_addr;

  // Observed values of the latest cycle
  bit            obs_busy, obs_done, obs_rgnt, obs_wgnt, obs_rv;
  logic [DW-1:0] obs_rdata, obs_d;

  task automatic model_reset();
    m_busy = 1; m_idx = 0; m_lfsr = SEED; m_done = 0; m_rv = 0;
    m_rr_wr_last = 0; m_addr = '0;
  endtask

  // Called #1 after a rising edge with inputs set; returns #1 after the next rising edge.
  task automatic cycle();
    bit eg_w, eg_r;
    logic [AW-1:0] e_addr;
    @(negedge Clock);
    obs_busy = init_busy; obs_done = init_done; obs_rgnt = rd_gnt; obs_wgnt = wr_gnt;
    obs_rv = rd_valid; obs_rdata = rd_data; obs_d = ram_d;
    if (!Rst) begin
      model_reset();
      check("rst_busy", init_busy, 1);
      check("rst_done", init_done, 0);
      check("rst_rvalid", rd_valid, 0);
      check("rst_gnt", {rd_gnt, wr_gnt}, 0);
      @(posedge Clock); #1;
      return;
    end
    eg_w = 0; eg_r = 0;
    if (!m_busy && !init_req) begin
      if (wr_req && rd_req) begin
`ifdef WCTRL_ROUND_ROBIN_EN
        if (m_rr_wr_last) eg_r = 1; else eg_w = 1;
`else
        eg_w = 1;
`endif
      end else begin
        eg_w = wr_req;
        eg_r = rd_req;
      end
    end
    e_addr = m_busy ? AW'(m_idx) : eg_w ? wr_addr : eg_r ? rd_addr : m_addr;
    check("busy", init_busy, m_busy);
    check("done", init_done, m_done);
    check("rd_valid", rd_valid, m_rv);
    if (m_rv) check("rd_data", rd_data, m_rdata);
    check("rd_gnt", rd_gnt, eg_r);
    check("wr_gnt", wr_gnt, eg_w);
    check("ram_we", ram_we, m_busy || eg_w);
    check("ram_addr", ram_addr, e_addr);
    if (m_busy) check("ram_d_init", ram_d, m_lfsr);
    else if (eg_w) check("ram_d_wr", ram_d, wr_data);
    @(posedge Clock);
    m_done = 0;
    m_rv = eg_r;
    if (eg_r) m_rdata = m_mem[rd_addr];
    if (eg_w) m_mem[wr_addr] = wr_data;
    if (eg_w) m_rr_wr_last = 1;
    else if (eg_r) m_rr_wr_last = 0;
    if (m_busy) begin
      m_mem[m_idx] = m_lfsr;
      m_lfsr = lfsr_step(m_lfsr);
      m_idx++;
      if (m_idx == DEPTH) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (init_req) begin
      m_busy = 1;
      m_idx = 0;
    end
    m_addr = e_addr;
    #1;
  endtask

  initial begin
    int n, busy_n;
    logic [3:0] wpat;
    Rst = 1'b1;
    #2 Rst = 1'b0;
    model_reset();
    cycle();
    cycle();
    Rst = 1'b1;

    // Power-up sweep
    n = 0; busy_n = 0;
    check("first_seed", ram_d, SEED);
    do begin
      cycle();
      busy_n += int'(obs_busy);
      n++;
    end while (!obs_done && n < 300);
    check("sweep1_len", busy_n, DEPTH);
    check("sweep1_done", obs_done, 1);

    // Read of address 1
    rd_req = 1; rd_addr = 7'd1;
    cycle();
    check("t2_gnt", obs_rgnt, 1);
    rd_req = 0;
    cycle();
    check("t2_valid", obs_rv, 1);
    check("t2_data", obs_rdata, 10'h34A);

    // Write then read back same address
    wr_req = 1; wr_addr = 7'd5; wr_data = 10'h3FF;
    cycle();
    check("t3_wgnt", obs_wgnt, 1);
    wr_req = 0; rd_req = 1; rd_addr = 7'd5;
    cycle();
    check("t3_rgnt", obs_rgnt, 1);
    rd_req = 0;
    cycle();
    check("t3_data", obs_rdata, 10'h3FF);

    // Contested requests
    for (int i = 0; i < 4; i++) begin
      rd_req = 1; wr_req = 1;
      rd_addr = AW'($urandom); wr_addr = AW'($urandom); wr_data = DW'($urandom);
      cycle();
      wpat[i] = obs_wgnt;
    end
`ifdef WCTRL_ROUND_ROBIN_EN
    check("t4_pattern", wpat, 4'b0101);
`else
    check("t4_pattern", wpat, 4'b1111);
`endif
    rd_req = 0; wr_req = 0;
    cycle();

    // Re-sweep with a held read and an ignored second request
    rd_req = 1; rd_addr = AW'($urandom); init_req = 1;
    cycle();
    check("t5_nogrant", obs_rgnt, 0);
    init_req = 0;
    n = 0; busy_n = 0;
    do begin
      init_req = (n == 50);
      cycle();
      busy_n += int'(obs_busy);
      if (obs_rgnt) rd_req = 0;
      n++;
    end while (!obs_done && n < 300);
    init_req = 0;
    check("sweep2_len", busy_n, DEPTH);
    rd_req = 0;
    cycle();

    // Reset in the middle of a sweep
    init_req = 1;
    cycle();
    init_req = 0;
    n = 0;
    while (m_idx != 60 && n < 300) begin
      cycle();
      n++;
    end
    check("t6_reach60", m_idx, 60);
    Rst = 0;
    cycle();
    Rst = 1;
    check("t6_restart_d", ram_d, SEED);
    check("t6_restart_addr", ram_addr, 0);
    n = 0; busy_n = 0;
    do begin
      cycle();
      busy_n += int'(obs_busy);
      n++;
    end while (!obs_done && n < 300);
    check("sweep3_len", busy_n, DEPTH);

    // Random traffic; requests are held until granted
    for (int i = 0; i < 1500; i++) begin
      if (!rd_req || obs_rgnt) begin
        rd_req = 1'($urandom);
        rd_addr = AW'($urandom);
      end
      if (!wr_req || obs_wgnt) begin
        wr_req = ($urandom % 3) == 0;
        wr_addr = AW'($urandom);
        wr_data = DW'($urandom);
      end
      init_req = ($urandom % 400) == 0;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
